id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid.sv | 130 +++++++++++++
 tb/tb_id_ex_skid.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a one-entry skid buffer.
// The decode-side ready is a pure function of the registered occupancy, so
// there is no combinational path from ex_ready back to id_ready. Empty slots
// always hold an all-zero bubble (NOP), so ex_* reads as a bubble whenever
// ex_valid is low.
module id_ex_skid #(
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3,
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [ALUOP_W-1:0]   id_aluop,
   input  logic [ALUSEL_W-1:0]  id_alusel,
   input  logic [DATA_W-1:0]    id_reg1,
   input  logic [DATA_W-1:0]    id_reg2,
   input  logic [REGADDR_W-1:0] id_wd,
   input  logic                 id_wreg,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [ALUOP_W-1:0]   ex_aluop,
   output logic [ALUSEL_W-1:0]  ex_alusel,
   output logic [DATA_W-1:0]    ex_reg1,
   output logic [DATA_W-1:0]    ex_reg2,
   output logic [REGADDR_W-1:0] ex_wd,
   output logic                 ex_wreg,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int PAY_W = ALUOP_W + ALUSEL_W + 2 * DATA_W + REGADDR_W + 1;
   localparam logic [PAY_W-1:0] BUBBLE = '0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PAY_W-1:0] main_q, main_d;
   logic [PAY_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [PAY_W-1:0] in_pay;
   logic             in_fire;
   logic             out_fire;

   assign in_pay   = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};

   assign id_ready = (state_q != TWO);
   assign ex_valid = (state_q != EMPTY);
   assign in_fire  = id_valid & id_ready;
   assign out_fire = ex_valid & ex_ready;

   assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = main_q;
   assign stall_cnt = stall_cnt_q;

   // Next occupancy and slot contents; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_pay;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_pay;
            end else if (in_fire) begin
               skid_d  = in_pay;
               state_d = TWO;
            end else if (out_fire) begin
               main_d  = BUBBLE;
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_d  = skid_q;
               skid_d  = BUBBLE;
               state_d = ONE;
            end
         end
         default: begin
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
         state_d = EMPTY;
      end
   end

   // Saturating count of cycles where execute holds off a valid payload.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ex_valid && !ex_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State, slot and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_id_ex_skid.sv
// Testbench for id_ex_skid: directed scenarios plus a random valid/ready run,
// checked against a two-deep FIFO model of the stage.
module tb_id_ex_skid;

   localparam int ALUOP_W   = 8;
   localparam int ALUSEL_W  = 3;
   localparam int DATA_W    = 32;
   localparam int REGADDR_W = 5;
   localparam int CNT_W     = 4;
   localparam int PW        = ALUOP_W + ALUSEL_W + 2 * DATA_W + REGADDR_W + 1;
   localparam int CNT_SAT   = 15;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 flush = 1'b0;
   logic                 id_valid = 1'b0;
   logic                 id_ready;
   logic [ALUOP_W-1:0]   id_aluop = '0;
   logic [ALUSEL_W-1:0]  id_alusel = '0;
   logic [DATA_W-1:0]    id_reg1 = '0;
   logic [DATA_W-1:0]    id_reg2 = '0;
   logic [REGADDR_W-1:0] id_wd = '0;
   logic                 id_wreg = 1'b0;
   logic                 ex_valid;
   logic                 ex_ready = 1'b0;
   logic [ALUOP_W-1:0]   ex_aluop;
   logic [ALUSEL_W-1:0]  ex_alusel;
   logic [DATA_W-1:0]    ex_reg1;
   logic [DATA_W-1:0]    ex_reg2;
   logic [REGADDR_W-1:0] ex_wd;
   logic                 ex_wreg;
   logic [CNT_W-1:0]     stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: in-order queue of at most two instructions.
   logic [PW-1:0] mq[$];
   int            mcnt  = 0;
   bit            known = 1'b0;

   always #5 clk = ~clk;

   id_ex_skid #(
      .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .DATA_W(DATA_W),
      .REGADDR_W(REGADDR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
      .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
      .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk(input logic [ALUOP_W-1:0] op, input logic [ALUSEL_W-1:0] sel,
                                        input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                                        input logic [REGADDR_W-1:0] wd, input logic wreg);
      return {op, sel, r1, r2, wd, wreg};
   endfunction

   function automatic logic [PW-1:0] rnd_pay();
      return mk(ALUOP_W'($urandom), ALUSEL_W'($urandom), DATA_W'($urandom),
                DATA_W'($urandom), REGADDR_W'($urandom), 1'($urandom));
   endfunction

   // One clock cycle: drive inputs, check registered outputs against the
   // model, confirm id_ready ignores ex_ready, clock, then advance the model.
   task automatic step(input logic r, input logic f, input logic v,
                       input logic [PW-1:0] p, input logic rdy);
      logic [PW-1:0] exp_pay;
      bit            in_fire;
      bit            out_fire;
      rst      = r;
      flush    = f;
      id_valid = v;
      {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg} = p;
      ex_ready = rdy;
      in_fire  = 1'b0;
      out_fire = 1'b0;
      if (known) begin
         exp_pay = (mq.size() != 0) ? mq[0] : '0;
         chk("ex_valid", 128'(ex_valid), 128'(mq.size() != 0));
         chk("id_ready", 128'(id_ready), 128'(mq.size() < 2));
         chk("ex_payload", 128'({ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}), 128'(exp_pay));
         chk("stall_cnt", 128'(stall_cnt), 128'(mcnt));
         ex_ready = ~rdy;
         #1;
         chk("id_ready_vs_ex_ready", 128'(id_ready), 128'(mq.size() < 2));
         ex_ready = rdy;
         in_fire  = v && (mq.size() < 2);
         out_fire = (mq.size() != 0) && rdy;
      end
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         mcnt  = 0;
         known = 1'b1;
      end else if (known) begin
         if ((mq.size() != 0) && !rdy && (mcnt < CNT_SAT)) mcnt++;
         if (f) begin
            mq.delete();
         end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire) mq.push_back(p);
         end
      end
   endtask

   initial begin
      logic [PW-1:0] pa;
      logic [PW-1:0] pb;

      // Reset
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, rnd_pay(), 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);

      // Streaming with reg1 = 1,2,3...
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 1'b1, mk(ALUOP_W'($urandom), ALUSEL_W'($urandom), DATA_W'(i),
                                   DATA_W'($urandom), REGADDR_W'($urandom), 1'(i % 2)), 1'b1);
         chk("stream_reg1", 128'(ex_reg1), 128'(i));
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Back-pressure: A(wd=3), B(wd=4) with execute stalled
      pa = mk(8'h11, 3'd1, 32'hA, 32'hA, 5'd3, 1'b1);
      pb = mk(8'h22, 3'd2, 32'hB, 32'hB, 5'd4, 1'b0);
      step(1'b0, 1'b0, 1'b1, pa, 1'b0);
      step(1'b0, 1'b0, 1'b1, pb, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      chk("bp_ex_wd_held", 128'(ex_wd), 128'(3));
      chk("bp_id_ready_low", 128'(id_ready), 128'(0));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("bp_ex_wd_second", 128'(ex_wd), 128'(4));
      chk("bp_id_ready_back", 128'(id_ready), 128'(1));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Flush while full, with an input offered the same cycle
      step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      step(1'b0, 1'b1, 1'b1, mk(8'hFF, 3'd7, 32'hDEAD, 32'hBEEF, 5'd31, 1'b1), 1'b0);
      chk("flush_ex_valid", 128'(ex_valid), 128'(0));
      chk("flush_ex_wreg", 128'(ex_wreg), 128'(0));
      chk("flush_ex_aluop", 128'(ex_aluop), 128'(0));
      chk("flush_id_ready", 128'(id_ready), 128'(1));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Saturation of the stall counter
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("stall_saturated", 128'(stall_cnt), 128'(CNT_SAT));
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("stall_kept_by_flush", 128'(stall_cnt), 128'(CNT_SAT));

      // Reset mid-operation while full
      step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      step(1'b0, 1'b0, 1'b1, rnd_pay(), 1'b0);
      step(1'b1, 1'b0, 1'b1, rnd_pay(), 1'b1);
      chk("rst_ex_valid", 128'(ex_valid), 128'(0));
      chk("rst_id_ready", 128'(id_ready), 128'(1));
      chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
      chk("rst_ex_zero", 128'({ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}), 128'(0));

      // Random valid/ready traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         step(1'b0 == 1'($urandom_range(0, 127) != 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 31) == 0),
              1'($urandom),
              rnd_pay(),
              1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 0));
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
